// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered-read word memory between
// an instruction-fetch port and a data read/write port.
module mem_arbiter #(
  parameter int WORDS  = 1024,
  parameter int ADDR_W = 22
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_wstrb,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              m_is_inst,
  output logic [3:0]        m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  state_e            state_q, state_d;
  logic              lastInst_q, lastInst_d;
  logic              isInst_q, isInst_d;
  logic              isRead_q, isRead_d;
  logic              err_q, err_d;
  logic [3:0]        wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              pickInst;
  logic [ADDR_W-1:0] reqAddr;
  logic              reqErr;
  logic              doneRead;

  // On a tie the port that was not served last wins; a lone requester always wins.
  assign pickInst = i_valid && (!d_valid || !lastInst_q);
  assign reqAddr  = pickInst ? i_addr : d_addr;
  assign reqErr   = 32'(reqAddr) >= 32'(WORDS);

  always_comb begin
    state_d    = state_q;
    lastInst_d = lastInst_q;
    isInst_d   = isInst_q;
    isRead_d   = isRead_q;
    err_d      = err_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        wen_d = 4'b0000;
        if (i_valid || d_valid) begin
          lastInst_d = pickInst;
          isInst_d   = pickInst;
          addr_d     = reqAddr;
          err_d      = reqErr;
          if (pickInst) begin
            isRead_d = 1'b1;
            wdata_d  = 32'h0;
          end else begin
            isRead_d = (d_wstrb == 4'b0000);
            wdata_d  = d_wdata;
            wen_d    = reqErr ? 4'b0000 : d_wstrb;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wen_d   = 4'b0000;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        wen_d   = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  // Reset clears the write enable asynchronously, so a reset mid-ISSUE never writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      lastInst_q <= 1'b1;
      isInst_q   <= 1'b0;
      isRead_q   <= 1'b0;
      err_q      <= 1'b0;
      wen_q      <= 4'b0000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      lastInst_q <= lastInst_d;
      isInst_q   <= isInst_d;
      isRead_q   <= isRead_d;
      err_q      <= err_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign doneRead  = (state_q == DONE) && isRead_q && !err_q;

  assign i_ready   = (state_q == DONE) && isInst_q;
  assign i_err     = i_ready && err_q;
  assign i_rdata   = (doneRead && isInst_q) ? m_rdata : 32'h0;

  assign d_ready   = (state_q == DONE) && !isInst_q;
  assign d_err     = d_ready && err_q;
  assign d_rdata   = (doneRead && !isInst_q) ? m_rdata : 32'h0;

  assign m_is_inst = isInst_q;
  assign m_wen     = wen_q;
  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts grants,
// completion cycles, read data and memory contents.
module tb_mem_arbiter;
  localparam int WORDS  = 1024;
  localparam int ADDR_W = 22;

  logic              clk = 1'b0;
  logic              resetn;
  logic              i_valid, d_valid;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [3:0]        d_wstrb;
  logic [31:0]       d_wdata;
  logic              i_ready, d_ready, i_err, d_err, m_is_inst;
  logic [31:0]       i_rdata, d_rdata, m_wdata;
  logic [31:0]       m_rdata = 32'h0;
  logic [3:0]        m_wen;
  logic [ADDR_W-1:0] m_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_valid(d_valid), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .m_is_inst(m_is_inst), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Physical memory: out-of-range addresses alias onto low words, so stray writes show up.
  logic [31:0] memArr [WORDS];
  int memIdx;
  always @(posedge clk) begin
    memIdx = int'(m_addr) % WORDS;
    for (int b = 0; b < 4; b++)
      if (m_wen[b]) memArr[memIdx][8*b +: 8] <= m_wdata[8*b +: 8];
    m_rdata <= memArr[memIdx];
  end

  typedef struct {
    int                issueCycle;
    bit                isInst;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        wen;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    bit                err;
  } txn_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        strb;
    logic [31:0]       data;
  } req_t;

  logic [31:0] refMem [WORDS];
  txn_t pend[$];
  req_t iQ[$];
  req_t dQ[$];
  int   cycle, nextGrant, testsRun, testsFailed, readyCount;
  bit   lastInst;
  logic [7:0] readyLog;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " i_ready"}, 64'(i_ready), 64'd0);
    checkOutput({tag, " d_ready"}, 64'(d_ready), 64'd0);
    checkOutput({tag, " i_err"}, 64'(i_err), 64'd0);
    checkOutput({tag, " d_err"}, 64'(d_err), 64'd0);
    checkOutput({tag, " i_rdata"}, 64'(i_rdata), 64'd0);
    checkOutput({tag, " d_rdata"}, 64'(d_rdata), 64'd0);
    checkOutput({tag, " m_wen"}, 64'(m_wen), 64'd0);
    checkOutput({tag, " m_addr"}, 64'(m_addr), 64'd0);
    checkOutput({tag, " m_wdata"}, 64'(m_wdata), 64'd0);
    checkOutput({tag, " m_is_inst"}, 64'(m_is_inst), 64'd0);
  endtask

  // Compare every DUT output with what the model says this cycle should show.
  task automatic checkCycle();
    txn_t t;
    logic expIR = 0, expDR = 0, expIE = 0, expDE = 0;
    logic [31:0] expIRd = 0, expDRd = 0;
    logic [3:0]  expWen = 0;
    if (pend.size() > 0) begin
      t = pend[0];
      if (t.issueCycle == cycle) begin
        expWen = t.wen;
        checkOutput("issue m_is_inst", 64'(m_is_inst), 64'(t.isInst));
        checkOutput("issue m_addr", 64'(m_addr), 64'(t.addr));
        checkOutput("issue m_wdata", 64'(m_wdata), 64'(t.wdata));
      end else if (t.issueCycle + 1 == cycle) begin
        if (t.isInst) begin
          expIR = 1; expIE = t.err; expIRd = t.rdata;
          if (iQ.size() > 0) void'(iQ.pop_front());
        end else begin
          expDR = 1; expDE = t.err; expDRd = t.rdata;
          if (dQ.size() > 0) void'(dQ.pop_front());
        end
        for (int b = 0; b < 4; b++)
          if (t.wen[b]) refMem[int'(t.addr)][8*b +: 8] = t.wdata[8*b +: 8];
        void'(pend.pop_front());
      end
    end
    checkOutput("i_ready", 64'(i_ready), 64'(expIR));
    checkOutput("d_ready", 64'(d_ready), 64'(expDR));
    checkOutput("i_err", 64'(i_err), 64'(expIE));
    checkOutput("d_err", 64'(d_err), 64'(expDE));
    checkOutput("i_rdata", 64'(i_rdata), 64'(expIRd));
    checkOutput("d_rdata", 64'(d_rdata), 64'(expDRd));
    checkOutput("m_wen", 64'(m_wen), 64'(expWen));
    if (d_ready) begin readyLog = {readyLog[6:0], 1'b0}; readyCount++; end
    if (i_ready) begin readyLog = {readyLog[6:0], 1'b1}; readyCount++; end
  endtask

  task automatic applyStimulus();
    i_valid = (iQ.size() > 0);
    i_addr  = i_valid ? iQ[0].addr : '0;
    d_valid = (dQ.size() > 0);
    d_addr  = d_valid ? dQ[0].addr : '0;
    d_wstrb = d_valid ? dQ[0].strb : 4'b0;
    d_wdata = d_valid ? dQ[0].data : 32'h0;
  endtask

  // Transaction-level arbiter: one grant per 3 cycles, round-robin on ties.
  task automatic modelGrant();
    txn_t t;
    req_t r;
    bit   winI, isRead;
    if (cycle >= nextGrant && (iQ.size() > 0 || dQ.size() > 0)) begin
      winI = (iQ.size() > 0) && (dQ.size() == 0 || !lastInst);
      r = winI ? iQ[0] : dQ[0];
      t.issueCycle = cycle + 1;
      t.isInst = winI;
      t.addr   = r.addr;
      t.err    = int'(r.addr) >= WORDS;
      isRead   = winI || (r.strb == 4'b0);
      t.wen    = (winI || t.err) ? 4'b0 : r.strb;
      t.wdata  = winI ? 32'h0 : r.data;
      t.rdata  = (isRead && !t.err) ? refMem[int'(r.addr)] : 32'h0;
      pend.push_back(t);
      lastInst  = winI;
      nextGrant = cycle + 3;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    checkCycle();
    applyStimulus();
    modelGrant();
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    cycle++;
    checkCycle();
    resetn = 1'b0;
    #1;
    checkResetOutputs("rst");
    pend.delete();
    iQ.delete();
    dQ.delete();
    lastInst = 1'b1;
    applyStimulus();
    @(posedge clk);
    #1;
    cycle++;
    resetn = 1'b1;
    nextGrant = cycle;
    checkCycle();
    applyStimulus();
    modelGrant();
  endtask

  task automatic drain(input int limit);
    for (int k = 0; k < limit && (iQ.size() > 0 || dQ.size() > 0 || pend.size() > 0); k++) tick();
    checkOutput("drain timeout", 64'(iQ.size() + dQ.size() + pend.size()), 64'd0);
  endtask

  function automatic logic [ADDR_W-1:0] randAddr();
    int r;
    r = $urandom % 16;
    if (r < 12)       return ADDR_W'($urandom % 16);
    else if (r == 12) return ADDR_W'(WORDS - 1);
    else if (r == 13) return ADDR_W'(WORDS);
    else if (r == 14) return ADDR_W'($urandom);
    else              return ADDR_W'(WORDS - 4 + int'($urandom % 4));
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req_t r;
    testsRun = 0; testsFailed = 0; readyLog = 0; readyCount = 0;
    resetn = 1'b0;
    i_valid = 0; i_addr = '0; d_valid = 0; d_addr = '0; d_wstrb = 0; d_wdata = 0;
    for (int a = 0; a < WORDS; a++) begin
      memArr[a] = $urandom;
      refMem[a] = memArr[a];
    end
    memArr[5] = 32'h00000013; refMem[5] = 32'h00000013;
    memArr[7] = 32'h11223344; refMem[7] = 32'h11223344;
    #3;
    checkResetOutputs("por");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cycle = 0; nextGrant = 0; lastInst = 1'b1;
    applyStimulus();
    modelGrant();

    r = '{addr: 5, strb: 4'b0, data: 32'h0};
    iQ.push_back(r);
    drain(20);

    r = '{addr: 7, strb: 4'b0011, data: 32'hAABBCCDD};
    dQ.push_back(r);
    r = '{addr: 7, strb: 4'b0000, data: 32'h0};
    dQ.push_back(r);
    drain(20);
    checkOutput("mem7 merge", 64'(memArr[7]), 64'h1122CCDD);

    r = '{addr: ADDR_W'(WORDS), strb: 4'b1111, data: 32'hCAFEF00D};
    dQ.push_back(r);
    drain(20);
    checkOutput("oor mem0", 64'(memArr[0]), 64'(refMem[0]));
    checkOutput("oor mem1023", 64'(memArr[WORDS-1]), 64'(refMem[WORDS-1]));

    pulseReset();
    readyLog = 0; readyCount = 0;
    for (int k = 1; k <= 2; k++) begin
      r = '{addr: ADDR_W'(k), strb: 4'b0, data: 32'h0};
      iQ.push_back(r);
      r = '{addr: ADDR_W'(k + 2), strb: 4'b0, data: 32'h0};
      dQ.push_back(r);
    end
    repeat (12) tick();
    checkOutput("tie count", 64'(readyCount), 64'd4);
    checkOutput("tie order", 64'(readyLog[3:0]), 64'b0101);
    drain(20);

    r = '{addr: 9, strb: 4'b1111, data: 32'hDEADBEEF};
    dQ.push_back(r);
    for (int k = 0; k < 10 && pend.size() == 0; k++) tick();
    checkOutput("rst grant seen", 64'(pend.size()), 64'd1);
    pulseReset();
    repeat (4) tick();
    checkOutput("rst no write", 64'(memArr[9]), 64'(refMem[9]));

    repeat (800) begin
      if (iQ.size() == 0 && ($urandom % 3) == 0) begin
        r = '{addr: randAddr(), strb: 4'b0, data: 32'h0};
        iQ.push_back(r);
      end
      if (dQ.size() == 0 && ($urandom % 3) == 0) begin
        r.addr = randAddr();
        r.strb = (($urandom % 2) == 0) ? 4'b0 : 4'($urandom);
        r.data = $urandom;
        dQ.push_back(r);
      end
      tick();
    end
    drain(20);

    for (int a = 0; a < 16; a++) checkOutput("final mem", 64'(memArr[a]), 64'(refMem[a]));
    for (int a = WORDS - 4; a < WORDS; a++) checkOutput("final mem top", 64'(memArr[a]), 64'(refMem[a]));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
